// File: rtl/sw_enc_pkg.sv
// Shared constants and types for the switch encoder: code record, its reset
// value and the debounce counter width helper.
package sw_enc_pkg;

    localparam int ENC_W  = 4;
    localparam int MAX_IN = 16;

    typedef struct packed {
        logic             none;
        logic [ENC_W-1:0] enc;
    } code_t;

    localparam code_t CODE_RST = '{none: 1'b1, enc: '0};

    // Bits needed to count 0 .. n-1 (at least one bit).
    function automatic int db_cnt_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch bit: two-flop synchroniser followed by a hold-time debouncer.
// The debounced level only moves after the synced level differs for DB_CNT cycles.
module sw_debounce
    import sw_enc_pkg::*;
#(
    parameter int DB_CNT = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_raw,
    output logic sw_db
);

    localparam int CNT_W = db_cnt_w(DB_CNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);

    logic             meta_reg;
    logic             sync_reg;
    logic             db_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= sw_raw;
            sync_reg <= meta_reg;
        end
    end

    // Any return to the accepted level restarts the hold window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_reg  <= 1'b0;
            cnt_reg <= '0;
        end else if (sync_reg == db_reg) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            db_reg  <= sync_reg;
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign sw_db = db_reg;

endmodule

// File: rtl/sw_enc.sv
// Switch encoder top: per-bit debounce, priority encode of the highest active
// switch and a latest-wins valid/ack event register. SW_ENC_OVR_EN builds the sticky overrun flag.
module sw_enc
    import sw_enc_pkg::*;
#(
    parameter int N_IN   = 10,
    parameter int DB_CNT = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IN-1:0]  sw_raw,
    input  logic             ack,
    output logic [N_IN-1:0]  sw_db,
    output logic [ENC_W-1:0] enc,
    output logic             none,
    output logic             enc_vld,
    output logic             ovr
);

    code_t code_next;
    code_t code_reg;
    logic  vld_reg;
    logic  change;

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_db
        sw_debounce #(
            .DB_CNT (DB_CNT)
        ) u_db (
            .clk    (clk),
            .rst    (rst),
            .sw_raw (sw_raw[gi]),
            .sw_db  (sw_db[gi])
        );
    end

    // Ascending scan so the highest set index is the one that sticks.
    always_comb begin
        code_next = CODE_RST;
        for (int i = 0; i < N_IN; i++) begin
            if (sw_db[i]) begin
                code_next.none = 1'b0;
                code_next.enc  = ENC_W'(i);
            end
        end
    end

    // code_reg is both the presented code and the last-reported code.
    assign change = (code_next != code_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_reg <= CODE_RST;
            vld_reg  <= 1'b0;
        end else if (change) begin
            code_reg <= code_next;
            vld_reg  <= 1'b1;
        end else if (ack && vld_reg) begin
            vld_reg  <= 1'b0;
        end
    end

    assign enc     = code_reg.enc;
    assign none    = code_reg.none;
    assign enc_vld = vld_reg;

`ifdef SW_ENC_OVR_EN
    logic ovr_reg;

    // A change landing on a still-pending code without an ack loses that code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_reg <= 1'b0;
        end else if (change && vld_reg && !ack) begin
            ovr_reg <= 1'b1;
        end
    end

    assign ovr = ovr_reg;
`else
    assign ovr = 1'b0;
`endif

endmodule

// File: tb/tb_sw_enc.sv
// Self-checking bench for sw_enc (N_IN=10, DB_CNT=4): expected codes are queued
// when switches are driven and compared when the encoder raises an event.
module tb_sw_enc;

    localparam int N_IN   = 10;
    localparam int DB_CNT = 4;
`ifdef SW_ENC_OVR_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic [N_IN-1:0] sw_raw;
    logic            ack;
    logic [N_IN-1:0] sw_db;
    logic [3:0]      enc;
    logic            none;
    logic            enc_vld;
    logic            ovr;

    int total;
    int bad;
    logic [4:0] sb[$];
    logic       vld_prev;
    logic [4:0] code_prev;
    logic       vld_seen;

    sw_enc #(
        .N_IN   (N_IN),
        .DB_CNT (DB_CNT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sw_raw  (sw_raw),
        .ack     (ack),
        .sw_db   (sw_db),
        .enc     (enc),
        .none    (none),
        .enc_vld (enc_vld),
        .ovr     (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_sb(input int max_cyc);
        int n;
        n = 0;
        while (sb.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
    endtask

    // Event monitor: a rising valid or a changed code while valid is a new report.
    always @(negedge clk) begin : monitor
        logic [4:0] exp_code;
        if (enc_vld && (!vld_prev || {none, enc} != code_prev)) begin
            if (sb.size() == 0) begin
                check("evt_unexpected", 32'(sb.size()), 32'd1);
            end else begin
                exp_code = sb.pop_front();
                $display("evt none=%0b enc=%0d expected=%0h", none, enc, exp_code);
                check("evt_code", 32'({none, enc}), 32'(exp_code));
            end
        end
        vld_prev  <= enc_vld;
        code_prev <= {none, enc};
    end

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        sw_raw   = '0;
        ack      = 1'b0;
        vld_prev = 1'b0;
        code_prev = 5'h10;
        vld_seen = 1'b0;

        // Reset values
        @(negedge clk);
        check("rst_sw_db", 32'(sw_db), 32'd0);
        check("rst_enc", 32'(enc), 32'd0);
        check("rst_none", 32'(none), 32'd1);
        check("rst_vld", 32'(enc_vld), 32'd0);
        check("rst_ovr", 32'(ovr), 32'd0);
        tick(2);
        rst = 1'b0;

        // 1: idle for 50 cycles, no event
        repeat (50) begin
            @(negedge clk);
            vld_seen = vld_seen | enc_vld;
        end
        check("idle_vld", 32'(vld_seen), 32'd0);
        check("idle_none", 32'(none), 32'd1);
        check("idle_enc", 32'(enc), 32'd0);

        // 2: single switch, exact latency, then ack
        tick(1);
        sw_raw = 10'h004;
        sb.push_back(5'h02);
        tick(5);
        @(negedge clk);
        check("t2_sw_db_early", 32'(sw_db), 32'h000);
        tick(1);
        @(negedge clk);
        check("t2_sw_db", 32'(sw_db), 32'h004);
        check("t2_vld_early", 32'(enc_vld), 32'd0);
        tick(1);
        @(negedge clk);
        check("t2_enc", 32'(enc), 32'd2);
        check("t2_none", 32'(none), 32'd0);
        check("t2_vld", 32'(enc_vld), 32'd1);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        @(negedge clk);
        check("t2_vld_acked", 32'(enc_vld), 32'd0);
        check("t2_enc_hold", 32'(enc), 32'd2);
        ack = 1'b1;
        tick(2);
        ack = 1'b0;
        @(negedge clk);
        check("t2_idle_ack", 32'(enc_vld), 32'd0);

        // 3: 3-cycle glitch on bit 5 is rejected
        tick(1);
        sw_raw = 10'h024;
        tick(3);
        sw_raw = 10'h004;
        tick(10);
        @(negedge clk);
        check("t3_sw_db", 32'(sw_db), 32'h004);
        check("t3_vld", 32'(enc_vld), 32'd0);

        // 4: highest bit wins, then clear all
        tick(1);
        sw_raw = 10'h204;
        sb.push_back(5'h09);
        wait_sb(30);
        check("t4_enc", 32'(enc), 32'd9);
        check("t4_vld", 32'(enc_vld), 32'd1);
        do_ack();
        tick(1);
        sw_raw = 10'h000;
        sb.push_back(5'h10);
        wait_sb(30);
        check("t4_none", 32'(none), 32'd1);
        check("t4_vld_clr", 32'(enc_vld), 32'd1);
        do_ack();

        // 5: latest-wins overwrite, then ack colliding with a new change
        tick(1);
        sw_raw = 10'h004;
        sb.push_back(5'h02);
        wait_sb(30);
        check("t5_ovr_before", 32'(ovr), 32'd0);
        tick(1);
        sw_raw = 10'h020;
        sb.push_back(5'h05);
        wait_sb(30);
        check("t5_enc_latest", 32'(enc), 32'd5);
        check("t5_vld", 32'(enc_vld), 32'd1);
        check("t5_ovr", 32'(ovr), 32'(OVR_EXP));
        tick(1);
        sw_raw = 10'h001;
        sb.push_back(5'h00);
        tick(5);
        tick(1);
        @(negedge clk);
        check("t5_pending", 32'({none, enc}), 32'h05);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        @(negedge clk);
        check("t5_vld_collide", 32'(enc_vld), 32'd1);
        check("t5_code_collide", 32'({none, enc}), 32'h00);
        do_ack();
        @(negedge clk);
        check("t5_vld_final", 32'(enc_vld), 32'd0);

        // 6: reset mid-debounce, then re-report after DB_CNT+3 cycles
        tick(1);
        sw_raw = 10'h100;
        tick(3);
        rst = 1'b1;
        #2;
        check("t6_rst_sw_db", 32'(sw_db), 32'd0);
        check("t6_rst_code", 32'({none, enc}), 32'h10);
        check("t6_rst_vld", 32'(enc_vld), 32'd0);
        check("t6_rst_ovr", 32'(ovr), 32'd0);
        tick(2);
        rst = 1'b0;
        sb.push_back(5'h08);
        tick(DB_CNT + 2);
        @(negedge clk);
        check("t6_vld_early", 32'(enc_vld), 32'd0);
        tick(1);
        @(negedge clk);
        check("t6_vld", 32'(enc_vld), 32'd1);
        check("t6_enc", 32'(enc), 32'd8);
        wait_sb(5);
        do_ack();
        tick(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
